// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-step iterative mult/div unit writing HI/LO.
// All data outputs are the EX/MEM pipeline register; stall is combinational back to ID/EX.
module ex_stage #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  writeBackIn,
    input  logic [2:0]  memoryIn,
    input  logic [1:0]  ALUop,
    input  logic        ALUSrc,
    input  logic        RegDst,
    input  logic [31:0] pcIn,
    input  logic [31:0] register1In,
    input  logic [31:0] register2In,
    input  logic [31:0] offsetIn,
    input  logic [4:0]  registerTargetIn,
    input  logic [4:0]  registerDestinationIn,
    output logic        stall,
    output logic [1:0]  writeBackOut,
    output logic [2:0]  memoryOut,
    output logic [31:0] aluResultOut,
    output logic [31:0] writeDataOut,
    output logic [4:0]  destRegOut,
    output logic        zeroOut,
    output logic [31:0] branchTargetOut
);

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t      r_state, w_state_next;
    logic [5:0]  r_count;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_acc, r_q, r_opb, r_rs;
    logic        r_is_div, r_neg_q, r_neg_r, r_div_zero;

    logic [1:0]  r_wb;
    logic [2:0]  r_mem;
    logic [31:0] r_result, r_wdata, r_branch;
    logic [4:0]  r_dest;
    logic        r_zero;

    logic [5:0]  w_funct;
    logic [4:0]  w_shamt;
    logic [31:0] w_opb, w_result;
    logic        w_is_muldiv, w_last, w_stall;

    assign w_funct     = offsetIn[5:0];
    assign w_shamt     = offsetIn[10:6];
    assign w_opb       = ALUSrc ? offsetIn : register2In;
    assign w_is_muldiv = (ALUop == 2'b10) &&
                         (w_funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign w_last      = (r_count == 6'(MULDIV_CYCLES - 1));

    always_comb begin
        w_result = '0;
        case (ALUop)
            2'b00: w_result = register1In + w_opb;
            2'b01: w_result = register1In - w_opb;
            2'b11: w_result = register1In | {16'b0, offsetIn[15:0]};
            default: begin
                case (w_funct)
                    F_ADD:   w_result = register1In + w_opb;
                    F_SUB:   w_result = register1In - w_opb;
                    F_AND:   w_result = register1In & w_opb;
                    F_OR:    w_result = register1In | w_opb;
                    F_SLT:   w_result = {31'b0, ($signed(register1In) < $signed(w_opb))};
                    F_SLL:   w_result = w_opb << w_shamt;
                    F_SRL:   w_result = w_opb >> w_shamt;
                    F_MFHI:  w_result = r_hi;
                    F_MFLO:  w_result = r_lo;
                    default: w_result = '0;
                endcase
            end
        endcase
    end

    // Engine works on magnitudes; signs are reapplied once at the final step.
    logic        w_signed, w_div, w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    assign w_signed = ~w_funct[0];
    assign w_div    = w_funct[1];
    assign w_a_neg  = w_signed & register1In[31];
    assign w_b_neg  = w_signed & register2In[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - register1In) : register1In;
    assign w_b_mag  = w_b_neg ? (32'd0 - register2In) : register2In;

    logic [32:0] w_sum, w_shift;
    logic        w_ge;
    logic [31:0] w_step_acc, w_step_q, w_quo, w_rem, w_fin_hi, w_fin_lo;
    logic [63:0] w_prod, w_prod_fix;

    assign w_sum      = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opb} : 33'd0);
    assign w_shift    = {r_acc, r_q[31]};
    assign w_ge       = (w_shift >= {1'b0, r_opb});
    assign w_step_acc = r_is_div ? (w_ge ? (w_shift[31:0] - r_opb) : w_shift[31:0])
                                 : w_sum[32:1];
    assign w_step_q   = r_is_div ? {r_q[30:0], w_ge} : {w_sum[0], r_q[31:1]};
    assign w_prod     = {w_step_acc, w_step_q};
    assign w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;
    assign w_quo      = r_neg_q ? (32'd0 - w_step_q) : w_step_q;
    assign w_rem      = r_neg_r ? (32'd0 - w_step_acc) : w_step_acc;
    assign w_fin_hi   = r_is_div ? (r_div_zero ? r_rs : w_rem) : w_prod_fix[63:32];
    assign w_fin_lo   = r_is_div ? (r_div_zero ? 32'hFFFF_FFFF : w_quo) : w_prod_fix[31:0];

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_muldiv) begin
                    w_state_next = S_BUSY;
                    w_stall      = 1'b1;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            // The held instruction retires here and must not re-trigger the engine.
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign stall = w_stall;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_opb      <= '0;
            r_rs       <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_muldiv) begin
                        r_count    <= '0;
                        r_acc      <= '0;
                        r_q        <= w_div ? w_a_mag : w_b_mag;
                        r_opb      <= w_div ? w_b_mag : w_a_mag;
                        r_rs       <= register1In;
                        r_is_div   <= w_div;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= (register2In == 32'd0);
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_step_acc;
                    r_q     <= w_step_q;
                    r_count <= r_count + 6'd1;
                    if (w_last) begin
                        r_hi <= w_fin_hi;
                        r_lo <= w_fin_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_stall) begin
            r_wb     <= '0;
            r_mem    <= '0;
            r_result <= '0;
            r_wdata  <= '0;
            r_dest   <= '0;
            r_zero   <= 1'b0;
            r_branch <= '0;
        end else begin
            r_wb     <= writeBackIn;
            r_mem    <= memoryIn;
            r_result <= w_result;
            r_wdata  <= register2In;
            r_dest   <= RegDst ? registerDestinationIn : registerTargetIn;
            r_zero   <= (w_result == 32'd0);
            r_branch <= pcIn + {offsetIn[29:0], 2'b00};
        end
    end

    assign writeBackOut    = r_wb;
    assign memoryOut       = r_mem;
    assign aluResultOut    = r_result;
    assign writeDataOut    = r_wdata;
    assign destRegOut      = r_dest;
    assign zeroOut         = r_zero;
    assign branchTargetOut = r_branch;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register. Consumes its control fields (writeBack, memory, ALUop, ALUSrc, RegDst) and its data fields.
- Performs single-cycle ALU ops and a 32-cycle iterative multiply/divide into HI/LO, with a stall back to ID/EX.
- Results are registered into the EX/MEM boundary, so the outputs of this block are the EX/MEM register.

Parameters:
MULDIV_CYCLES, 32, iteration count of the mult/div engine (fixed at data width; not intended to change)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
writeBackIn  input  2  WB control from ID/EX
memoryIn  input  3  MEM control from ID/EX
ALUop  input  2  00 add, 01 sub, 10 R-type by funct, 11 or-immediate
ALUSrc  input  1  1: operand B = offsetIn; 0: operand B = register2In
RegDst  input  1  1: dest = registerDestinationIn; 0: dest = registerTargetIn
pcIn  input  32  PC+4 of the instruction
register1In  input  32  rs value (operand A)
register2In  input  32  rt value
offsetIn  input  32  sign-extended immediate; funct = [5:0], shamt = [10:6]
registerTargetIn  input  5  rt index
registerDestinationIn  input  5  rd index
stall  output  1  combinational; 1 means ID/EX and earlier stages must hold
writeBackOut  output  2  registered WB control
memoryOut  output  3  registered MEM control
aluResultOut  output  32  registered ALU/move result
writeDataOut  output  32  registered register2In (store data)
destRegOut  output  5  registered destination index
zeroOut  output  1  registered (ALU result == 0)
branchTargetOut  output  32  registered pcIn + (offsetIn << 2), mod 2^32

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset value: all outputs (except combinational stall) = 0; HI = LO = 0; FSM = IDLE.
- Reset mid mult/div aborts the operation and zeroes HI/LO; stall = 0 in the cycle after reset.
- Operand B = ALUSrc ? offsetIn : register2In.
- ALUop 00: A+B. ALUop 01: A-B. ALUop 11: A | {16'b0, offsetIn[15:0]}.
- ALUop 10, funct select:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
  - 0x2A slt: signed, result 1 or 0.
  - 0x00 sll: B << shamt. 0x02 srl: B >> shamt, logical.
  - 0x10 mfhi: result = HI. 0x12 mflo: result = LO.
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu: mult/div engine, result 0.
  - Any other funct: result 0.
- Arithmetic wraps mod 2^32; no overflow trap.
- Normal latency: 1 cycle. Inputs are sampled at posedge and appear on the EX/MEM outputs after that edge.
- FSM states:
  - IDLE: on a muldiv funct with ALUop 10, latch operands and signedness, go to BUSY, count = 0. stall = 1 in that cycle.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle. stall = 1. At count == MULDIV_CYCLES-1: write HI/LO and go to DONE.
  - DONE: stall = 0; the held muldiv instruction retires into EX/MEM. It must not restart. Next state is IDLE unconditionally.
- The ID/EX contents are stable for the whole operation, which is why DONE exists.
- Total stall for one muldiv: 33 cycles. HI/LO are updated at the BUSY->DONE edge.
- mfhi/mflo in the cycle after DONE read the new values. There is no forwarding of partial results.
- While stall = 1, EX/MEM loads a bubble: writeBackOut = 0, memoryOut = 0, all other outputs 0.
- Multiply:
  - mult: signed 64-bit product of magnitudes, negated if signs differ.
  - multu: unsigned product.
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - LO = quotient, HI = remainder.
  - div: quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero (div and divu): LO = 0xFFFFFFFF, HI = rs. No exception.
  - Signed div 0x80000000 / -1: LO = 0x80000000, HI = 0.
- zeroOut is computed on the final selected result, bubble included (bubble gives zeroOut = 0 because all outputs are forced 0).

Test Plan:
- Reset, then ALUop 00, ALUSrc 1, rs = 10, offset = -4 -> next cycle aluResultOut = 6, destRegOut = rt, writeBack/memory pass through unchanged.
- ALUop 01, rs = rt = 0x55, pcIn = 0x100, offset = 4 -> zeroOut = 1, branchTargetOut = 0x110.
- mult, rs = 7, rt = -3 -> stall high for exactly 33 cycles with bubbles in EX/MEM, then the mult retires. A following mflo returns 0xFFFFFFEB; mfhi returns 0xFFFFFFFF.
- divu 100/7 -> LO = 14, HI = 2. div -7/2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu 5/0 -> LO = 0xFFFFFFFF, HI = 5.
- R-type slt -1 vs 1 -> 1. sll rt = 1, shamt = 31 -> 0x80000000. srl rt = 0x80000000, shamt = 31 -> 1. Unknown funct 0x3F -> 0.
- Assert reset at BUSY count 10 -> next cycle stall = 0, HI = LO = 0, outputs 0. A new mult afterwards completes normally.
